// File: rtl/icw_sequencer.sv
// -----------------------------------------------------------------------------
// icw_sequencer
//
// Purpose:
//   Initialization-command-word sequencer for an 8259-style interrupt
//   controller. Tracks the ICW1..ICW4 write sequence, latches the
//   configuration fields of each word, and once the sequence completes
//   forwards every further (non-ICW1) write as an operation command word.
//   An ICW1 write restarts the sequence from any state.
//
// Ports:
//   clk          in   1  sole clock, rising edge
//   rst          in   1  asynchronous, active-high reset
//   wr           in   1  write strobe, one write per cycle sampled high
//   A0           in   1  address bit of the write
//   din          in   8  write data
//   ltim/adi/sngl/ic4       out 1  ICW1 D3/D2/D1/D0
//   vector_base             out 5  ICW2 D7..D3
//   cascade_cfg             out 8  raw ICW3 byte
//   upm/aeoi/ms/buf_mode/sfnm out 1 ICW4 D0..D4
//   init_done    out  1  high while the sequence is complete (READY)
//   ocw_wr       out  1  one-cycle pulse per OCW accepted in READY
//   ocw_a0       out  1  A0 of the last OCW
//   ocw_data     out  8  data of the last OCW
//   seq_err      out  1  one-cycle pulse on an out-of-sequence write
//
// All outputs are registered and change on the edge that samples wr.
// -----------------------------------------------------------------------------
module icw_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic       A0,
    input  logic [7:0] din,
    output logic       ltim,
    output logic       adi,
    output logic       sngl,
    output logic       ic4,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_cfg,
    output logic       upm,
    output logic       aeoi,
    output logic       ms,
    output logic       buf_mode,
    output logic       sfnm,
    output logic       init_done,
    output logic       ocw_wr,
    output logic       ocw_a0,
    output logic [7:0] ocw_data,
    output logic       seq_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    state_t     r_state,     w_state_nxt;

    // ICW1 fields packed as {ltim, adi, sngl, ic4} = din[3:0]
    logic [3:0] r_icw1,      w_icw1_nxt;
    logic [4:0] r_vec,       w_vec_nxt;
    logic [7:0] r_cas,       w_cas_nxt;
    // ICW4 fields packed as {sfnm, buf_mode, ms, aeoi, upm} = din[4:0]
    logic [4:0] r_icw4,      w_icw4_nxt;
    logic       r_init_done, w_init_done_nxt;
    logic       r_ocw_wr,    w_ocw_wr_nxt;
    logic       r_ocw_a0,    w_ocw_a0_nxt;
    logic [7:0] r_ocw_data,  w_ocw_data_nxt;
    logic       r_seq_err,   w_seq_err_nxt;

    // ICW1 is recognised in every state, so it is decoded ahead of the
    // per-state handling and always takes priority.
    logic       w_is_icw1;
    assign w_is_icw1 = wr & ~A0 & din[4];

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_icw1      <= '0;
            r_vec       <= '0;
            r_cas       <= '0;
            r_icw4      <= '0;
            r_init_done <= 1'b0;
            r_ocw_wr    <= 1'b0;
            r_ocw_a0    <= 1'b0;
            r_ocw_data  <= '0;
            r_seq_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_icw1      <= w_icw1_nxt;
            r_vec       <= w_vec_nxt;
            r_cas       <= w_cas_nxt;
            r_icw4      <= w_icw4_nxt;
            r_init_done <= w_init_done_nxt;
            r_ocw_wr    <= w_ocw_wr_nxt;
            r_ocw_a0    <= w_ocw_a0_nxt;
            r_ocw_data  <= w_ocw_data_nxt;
            r_seq_err   <= w_seq_err_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Configuration holds and pulses drop unless a write says otherwise.
        w_state_nxt    = r_state;
        w_icw1_nxt     = r_icw1;
        w_vec_nxt      = r_vec;
        w_cas_nxt      = r_cas;
        w_icw4_nxt     = r_icw4;
        w_ocw_a0_nxt   = r_ocw_a0;
        w_ocw_data_nxt = r_ocw_data;
        w_ocw_wr_nxt   = 1'b0;
        w_seq_err_nxt  = 1'b0;

        if (w_is_icw1) begin
            // Restart: ICW4 fields return to defaults because a new sequence
            // may skip ICW4; ICW2/ICW3 contents are simply overwritten later.
            w_icw1_nxt  = din[3:0];
            w_icw4_nxt  = '0;
            w_state_nxt = WAIT_ICW2;
        end else if (wr) begin
            unique case (r_state)
                IDLE: begin
                    w_seq_err_nxt = 1'b1;
                end
                WAIT_ICW2: begin
                    if (A0) begin
                        w_vec_nxt = din[7:3];
                        // sngl = r_icw1[1], ic4 = r_icw1[0]
                        if (!r_icw1[1]) begin
                            w_state_nxt = WAIT_ICW3;
                        end else if (r_icw1[0]) begin
                            w_state_nxt = WAIT_ICW4;
                        end else begin
                            w_state_nxt = READY;
                        end
                    end else begin
                        w_seq_err_nxt = 1'b1;
                    end
                end
                WAIT_ICW3: begin
                    if (A0) begin
                        w_cas_nxt   = din;
                        w_state_nxt = r_icw1[0] ? WAIT_ICW4 : READY;
                    end else begin
                        w_seq_err_nxt = 1'b1;
                    end
                end
                WAIT_ICW4: begin
                    if (A0) begin
                        w_icw4_nxt  = din[4:0];
                        w_state_nxt = READY;
                    end else begin
                        w_seq_err_nxt = 1'b1;
                    end
                end
                READY: begin
                    w_ocw_wr_nxt   = 1'b1;
                    w_ocw_a0_nxt   = A0;
                    w_ocw_data_nxt = din;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        // Registered alongside the state so it is high exactly in READY.
        w_init_done_nxt = (w_state_nxt == READY);
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign ltim        = r_icw1[3];
    assign adi         = r_icw1[2];
    assign sngl        = r_icw1[1];
    assign ic4         = r_icw1[0];
    assign vector_base = r_vec;
    assign cascade_cfg = r_cas;
    assign upm         = r_icw4[0];
    assign aeoi        = r_icw4[1];
    assign ms          = r_icw4[2];
    assign buf_mode    = r_icw4[3];
    assign sfnm        = r_icw4[4];
    assign init_done   = r_init_done;
    assign ocw_wr      = r_ocw_wr;
    assign ocw_a0      = r_ocw_a0;
    assign ocw_data    = r_ocw_data;
    assign seq_err     = r_seq_err;

endmodule
